ex_issue_ctrl: RTL and testbench
================================

// Module: ex_issue_ctrl
// PURPOSE
// - Sequences the EX stage operand datapath: registers the ALU operand-2 source select (00 reg, 01 imm, 10 const 4)
//   and the forwarding selects for operands A/B at the ID->EX boundary.
// - Detects load-use hazards and inserts one bubble; holds the pipe while a multi-cycle op (mul/div) occupies EX.
// - Sits between ID decode and the id_ex register / EX operand muxes.
// PARAMETERS
// - MC_TIMEOUT  default 64  max cycles in MC_BUSY before mcErr is raised and the FSM returns to RUN
// - CNT_W       default 7   width of multi-cycle counter (must hold MC_TIMEOUT)
// PORTS
// - clk          in   1  core clock, rising edge
// - rst_n        in   1  asynchronous active-low reset
// - id_valid     in   1  valid instruction in ID
// - id_rs1       in   5  ID source reg 1
// - id_rs2       in   5  ID source reg 2
// - id_useRs1    in   1  instr reads rs1
// - id_useRs2    in   1  instr reads rs2
// - id_rd        in   5  ID destination reg
// - id_regWrite  in   1  instr writes rd
// - id_memRead   in   1  instr is a load
// - id_isMulti   in   1  instr is multi-cycle (mul/div)
// - id_useImm    in   1  operand 2 from immediate
// - id_pcLink    in   1  jal/jalr: operand 2 = 4 (wins over id_useImm)
// - ex_mcDone    in   1  multi-cycle unit result ready (1-cycle pulse)
// - stall_if_id  out  1  hold PC and IF/ID register
// - bubble_ex    out  1  load NOP into id_ex this cycle
// - aluSrc2      out  2  registered operand-2 select for the EX mux
// - fwdA         out  2  registered: 00 regfile, 01 EX/MEM, 10 MEM/WB
// - fwdB         out  2  same encoding, for operand 2 when aluSrc2==00
// - mcStart      out  1  1-cycle start pulse to the multi-cycle unit
// - mcErr        out  1  sticky timeout flag, cleared only by reset
// BEHAVIOUR
// - Reset: all outputs 0; FSM=RUN; shadow EX/MEM stage rd/regWrite/memRead/isMulti cleared (bubbles).
// - Shadow pipe: exQ <= bubble_ex ? 0 : ID fields (when !stall); memQ <= exQ every cycle unless MC_BUSY.
// - Forwarding (computed in ID, registered into EX): the source equals exQ.rd -> 01 (EX/MEM next cycle);
//   otherwise equals memQ.rd -> 10; both require regWrite=1 and rd!=0; the EX/MEM match wins over MEM/WB;
//   a source of x0 is never forwarded.
// - Load-use hazard: id_valid & exQ.memRead & exQ.rd!=0 & ((useRs1&rs1==rd)|(useRs2&rs2==rd)).
//   Comb. stall_if_id=1 and bubble_ex=1 for exactly one cycle. The next cycle forwards 10 from MEM/WB.
// - aluSrc2 <= pcLink ? 2'b10 : useImm ? 2'b01 : 2'b00. Encoding 11 is never driven.
//   Held during stall; 00 on bubble.
// - FSM states:
//   RUN: an instruction with isMulti is latched into exQ -> mcStart=1 same edge -> MC_BUSY, counter=0.
//   MC_BUSY: stall_if_id=1, bubble_ex=0, id_ex and shadow pipe frozen; counter++ each cycle.
//     ex_mcDone -> RUN (stall drops the same cycle as ex_mcDone).
//     counter==MC_TIMEOUT-1 without done -> mcErr=1, RUN.
//   ex_mcDone outside MC_BUSY is ignored.
// - Simultaneous load-use and MC_BUSY: MC_BUSY freeze dominates. The hazard is re-evaluated after exit.
// - Async reset mid MC_BUSY: immediate return to RUN, mcStart/stall low, counter cleared.
// STRUCTURE
// - Shared package core_pkg: ALU_SRC2_REG/IMM/FOUR (2'b00/01/10), FWD_RF/EXMEM/MEMWB, FSM state enum.
// - One sub-module: ex_fwd_unit (combinational rs-vs-rd compare, priority, x0 exclusion), instantiated for A and B.
// TESTING
// - add x5 then add x6,x5,x1 back-to-back -> next-cycle fwdA=01, no stall.
// - add x5; nop; sub x7,x5,x2 -> fwdA=10. Same with rd=x0 -> fwdA=00.
// - lw x5 then add x6,x1,x5 -> stall_if_id=bubble_ex=1 one cycle, then fwdB=10, aluSrc2=00.
// - jal with useImm=1 -> aluSrc2=10. addi -> 01. EX/MEM and MEM/WB both write x5 -> fwdA=01.
// - div issue, ex_mcDone after 10 cycles -> mcStart one pulse, stall high 10 cycles, pipe frozen.
//   No done in 64 cycles -> mcErr=1, RUN.
// - rst_n low mid MC_BUSY -> all outputs 0 asynchronously. Resume with a clean RUN and no stale forwarding.

Source files
------------

// File: rtl/core_pkg.sv
// Shared encodings for the EX issue controller: operand-2 select, forwarding
// select, multi-cycle FSM states and the shadow-stage record.
package core_pkg;

  localparam logic [1:0] ALU_SRC2_REG  = 2'b00;
  localparam logic [1:0] ALU_SRC2_IMM  = 2'b01;
  localparam logic [1:0] ALU_SRC2_FOUR = 2'b10;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MC_BUSY = 1'b1
  } mc_state_e;

  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } stage_info_t;

  // Link instructions need the constant 4 even when an immediate is present.
  function automatic logic [1:0] alu_src2_sel(input logic pc_link, input logic use_imm);
    logic [1:0] sel;
    if (pc_link) begin
      sel = ALU_SRC2_FOUR;
    end else if (use_imm) begin
      sel = ALU_SRC2_IMM;
    end else begin
      sel = ALU_SRC2_REG;
    end
    return sel;
  endfunction

endpackage

// File: rtl/ex_fwd_unit.sv
// Forwarding select for one source operand: EX/MEM beats MEM/WB, x0 never forwards.
module ex_fwd_unit
  import core_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] ex_rd,
  input  logic       ex_reg_write,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  output logic [1:0] fwd
);

  // Priority compare of the source against the two younger-than-WB producers
  always_comb begin
    fwd = FWD_RF;
    if (src == 5'd0) begin
      fwd = FWD_RF;
    end else if (ex_reg_write && (ex_rd == src)) begin
      fwd = FWD_EXMEM;
    end else if (mem_reg_write && (mem_rd == src)) begin
      fwd = FWD_MEMWB;
    end else begin
      fwd = FWD_RF;
    end
  end

endmodule

// File: rtl/ex_issue_ctrl.sv
// ID->EX issue control: operand-select/forwarding registers, load-use bubble,
// and the multi-cycle hold FSM with a sticky timeout flag.
module ex_issue_ctrl
  import core_pkg::*;
#(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_useRs1,
  input  logic       id_useRs2,
  input  logic [4:0] id_rd,
  input  logic       id_regWrite,
  input  logic       id_memRead,
  input  logic       id_isMulti,
  input  logic       id_useImm,
  input  logic       id_pcLink,
  input  logic       ex_mcDone,
  output logic       stall_if_id,
  output logic       bubble_ex,
  output logic [1:0] aluSrc2,
  output logic [1:0] fwdA,
  output logic [1:0] fwdB,
  output logic       mcStart,
  output logic       mcErr
);

  mc_state_e        state_r, state_s;
  logic [CNT_W-1:0] cnt_r;
  stage_info_t      ex_q_r, id_info_s;
  logic [4:0]       mem_rd_r;
  logic             mem_reg_write_r;
  logic             freeze_s, hazard_s, start_s, timeout_s;
  logic [1:0]       src2_s, fwd_a_s, fwd_b_raw_s, fwd_b_s;
  logic [1:0]       alu_src2_r, fwd_a_r, fwd_b_r;
  logic             mc_start_r, mc_err_r;

  ex_fwd_unit u_fwd_a (
    .src(id_rs1), .ex_rd(ex_q_r.rd), .ex_reg_write(ex_q_r.reg_write),
    .mem_rd(mem_rd_r), .mem_reg_write(mem_reg_write_r), .fwd(fwd_a_s)
  );

  ex_fwd_unit u_fwd_b (
    .src(id_rs2), .ex_rd(ex_q_r.rd), .ex_reg_write(ex_q_r.reg_write),
    .mem_rd(mem_rd_r), .mem_reg_write(mem_reg_write_r), .fwd(fwd_b_raw_s)
  );

  // Issue decisions; the done cycle already releases the pipe so the waiting ID op is not lost
  always_comb begin
    id_info_s = '0;
    if (id_valid) begin
      id_info_s = '{rd: id_rd, reg_write: id_regWrite, mem_read: id_memRead};
    end else begin
      id_info_s = '0;
    end
    freeze_s  = (state_r == ST_MC_BUSY) && !ex_mcDone;
    hazard_s  = !freeze_s && id_valid && ex_q_r.mem_read && (ex_q_r.rd != 5'd0) &&
                ((id_useRs1 && (id_rs1 == ex_q_r.rd)) || (id_useRs2 && (id_rs2 == ex_q_r.rd)));
    start_s   = !freeze_s && !hazard_s && id_valid && id_isMulti;
    timeout_s = freeze_s && (cnt_r == CNT_W'(MC_TIMEOUT - 1));
    src2_s    = alu_src2_sel(id_pcLink, id_useImm);
    fwd_b_s   = (src2_s == ALU_SRC2_REG) ? fwd_b_raw_s : FWD_RF;
  end

  // FSM next-state
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (start_s) begin
          state_s = ST_MC_BUSY;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_MC_BUSY: begin
        if (ex_mcDone) begin
          state_s = start_s ? ST_MC_BUSY : ST_RUN;
        end else if (timeout_s) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_MC_BUSY;
        end
      end
      default: state_s = ST_RUN;
    endcase
  end

  // FSM state register and busy-cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      if (start_s) begin
        cnt_r <= '0;
      end else if (state_r == ST_MC_BUSY) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Shadow EX/MEM stages mirroring what id_ex and ex_mem hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q_r          <= '0;
      mem_rd_r        <= 5'd0;
      mem_reg_write_r <= 1'b0;
    end else if (!freeze_s) begin
      ex_q_r          <= hazard_s ? '0 : id_info_s;
      mem_rd_r        <= ex_q_r.rd;
      mem_reg_write_r <= ex_q_r.reg_write;
    end
  end

  // EX-side select registers; a bubble or empty slot selects regfile/reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_src2_r <= ALU_SRC2_REG;
      fwd_a_r    <= FWD_RF;
      fwd_b_r    <= FWD_RF;
      mc_start_r <= 1'b0;
      mc_err_r   <= 1'b0;
    end else begin
      mc_start_r <= start_s;
      mc_err_r   <= mc_err_r | timeout_s;
      if (freeze_s) begin
        alu_src2_r <= alu_src2_r;
      end else if (hazard_s || !id_valid) begin
        alu_src2_r <= ALU_SRC2_REG;
        fwd_a_r    <= FWD_RF;
        fwd_b_r    <= FWD_RF;
      end else begin
        alu_src2_r <= src2_s;
        fwd_a_r    <= fwd_a_s;
        fwd_b_r    <= fwd_b_s;
      end
    end
  end

  assign stall_if_id = freeze_s | hazard_s;
  assign bubble_ex   = hazard_s;
  assign aluSrc2     = alu_src2_r;
  assign fwdA        = fwd_a_r;
  assign fwdB        = fwd_b_r;
  assign mcStart     = mc_start_r;
  assign mcErr       = mc_err_r;

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Self-checking bench for ex_issue_ctrl: instruction-level pipeline model,
// directed scenarios with literal pins, then randomized traffic.
module tb_ex_issue_ctrl;

  localparam int MC_TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       id_valid = 1'b0, id_useRs1 = 1'b0, id_useRs2 = 1'b0;
  logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
  logic       id_regWrite = 1'b0, id_memRead = 1'b0, id_isMulti = 1'b0;
  logic       id_useImm = 1'b0, id_pcLink = 1'b0, ex_mcDone = 1'b0;
  logic       stall_if_id, bubble_ex, mcStart, mcErr;
  logic [1:0] aluSrc2, fwdA, fwdB;

  ex_issue_ctrl #(.MC_TIMEOUT(MC_TIMEOUT), .CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_useRs1(id_useRs1), .id_useRs2(id_useRs2), .id_rd(id_rd), .id_regWrite(id_regWrite),
    .id_memRead(id_memRead), .id_isMulti(id_isMulti), .id_useImm(id_useImm),
    .id_pcLink(id_pcLink), .ex_mcDone(ex_mcDone), .stall_if_id(stall_if_id),
    .bubble_ex(bubble_ex), .aluSrc2(aluSrc2), .fwdA(fwdA), .fwdB(fwdB),
    .mcStart(mcStart), .mcErr(mcErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit valid; int rs1; int rs2; bit u1; bit u2; int rd;
    bit wr; bit ld; bit mul; bit imm; bit link; bit done;
  } stim_t;

  typedef struct { int rd; bit wr; bit ld; } slot_t;

  // Model: which instruction sits in EX and MEM, plus what EX was issued with
  slot_t m_ex, m_mem;
  bit    m_busy, m_err, m_start;
  int    m_busy_n, m_src2, m_fa, m_fb;

  int checks = 0;
  int errors = 0;
  int obs_stall, obs_bubble, stall_cnt;

  function automatic stim_t ins(int rd, int rs1, int rs2, bit u1, bit u2, bit wr,
                                bit ld, bit mul, bit imm, bit link);
    stim_t s;
    s = '{1'b1, rs1, rs2, u1, u2, rd, wr, ld, mul, imm, link, 1'b0};
    return s;
  endfunction

  function automatic stim_t nop();
    stim_t s;
    s = '{1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    return s;
  endfunction

  // Where the value of register src comes from when this instruction reaches EX
  function automatic int fwd_of(int src);
    if (src == 0) return 0;
    if (m_ex.wr && m_ex.rd == src) return 1;
    if (m_mem.wr && m_mem.rd == src) return 2;
    return 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ex = '{0, 1'b0, 1'b0};
    m_mem = '{0, 1'b0, 1'b0};
    m_busy = 1'b0; m_err = 1'b0; m_start = 1'b0;
    m_busy_n = 0; m_src2 = 0; m_fa = 0; m_fb = 0;
  endtask

  task automatic drive(input stim_t s);
    id_valid = s.valid; id_rs1 = 5'(s.rs1); id_rs2 = 5'(s.rs2);
    id_useRs1 = s.u1; id_useRs2 = s.u2; id_rd = 5'(s.rd);
    id_regWrite = s.wr; id_memRead = s.ld; id_isMulti = s.mul;
    id_useImm = s.imm; id_pcLink = s.link; ex_mcDone = s.done;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_stall"}, int'(stall_if_id), 0);
    check({tag, "_bubble"}, int'(bubble_ex), 0);
    check({tag, "_aluSrc2"}, int'(aluSrc2), 0);
    check({tag, "_fwdA"}, int'(fwdA), 0);
    check({tag, "_fwdB"}, int'(fwdB), 0);
    check({tag, "_mcStart"}, int'(mcStart), 0);
    check({tag, "_mcErr"}, int'(mcErr), 0);
  endtask

  // One clock: drive at negedge, compare every output with the model, advance the model
  task automatic cycle(input stim_t s);
    bit frozen, haz;
    int ns2, nfa, nfb;
    @(negedge clk);
    drive(s);
    #1;
    frozen = m_busy && !s.done;
    haz = !frozen && s.valid && m_ex.ld && m_ex.rd != 0 &&
          ((s.u1 && s.rs1 == m_ex.rd) || (s.u2 && s.rs2 == m_ex.rd));
    check("stall", int'(stall_if_id), int'(frozen || haz));
    check("bubble", int'(bubble_ex), int'(haz));
    check("aluSrc2", int'(aluSrc2), m_src2);
    check("fwdA", int'(fwdA), m_fa);
    check("fwdB", int'(fwdB), m_fb);
    check("mcStart", int'(mcStart), int'(m_start));
    check("mcErr", int'(mcErr), int'(m_err));
    obs_stall = int'(stall_if_id);
    obs_bubble = int'(bubble_ex);
    @(posedge clk);
    if (frozen) begin
      m_start = 1'b0;
      if (m_busy_n == MC_TIMEOUT - 1) begin
        m_err = 1'b1;
        m_busy = 1'b0;
      end else begin
        m_busy_n++;
      end
    end else begin
      ns2 = s.link ? 2 : (s.imm ? 1 : 0);
      nfa = fwd_of(s.rs1);
      nfb = (ns2 == 0) ? fwd_of(s.rs2) : 0;
      m_mem = m_ex;
      if (s.valid && !haz) begin
        m_ex = '{s.rd, s.wr, s.ld};
        m_src2 = ns2; m_fa = nfa; m_fb = nfb;
        m_start = s.mul; m_busy = s.mul; m_busy_n = 0;
      end else begin
        m_ex = '{0, 1'b0, 1'b0};
        m_src2 = 0; m_fa = 0; m_fb = 0;
        m_start = 1'b0; m_busy = 1'b0;
      end
    end
    #1;
  endtask

  task automatic count_stalls(input int n, input stim_t s);
    stall_cnt = 0;
    for (int i = 0; i < n; i++) begin
      cycle(s);
      stall_cnt += obs_stall;
    end
  endtask

  initial begin
    stim_t held, done_s, r;
    model_reset();
    #2 rst_n = 1'b0;
    drive(nop());
    repeat (2) @(negedge clk);
    #1 check_zero("reset");
    rst_n = 1'b1;

    // add x5 ; add x6,x5,x1
    cycle(ins(5, 1, 2, 1, 1, 1, 0, 0, 0, 0));
    cycle(ins(6, 5, 1, 1, 1, 1, 0, 0, 0, 0));
    check("b2b_fwdA", int'(fwdA), 1);
    check("b2b_nostall", obs_stall, 0);

    // add x5 ; nop ; sub x7,x5,x2   then the same through x0
    cycle(ins(5, 1, 2, 1, 1, 1, 0, 0, 0, 0));
    cycle(nop());
    cycle(ins(7, 5, 2, 1, 1, 1, 0, 0, 0, 0));
    check("gap_fwdA", int'(fwdA), 2);
    cycle(ins(0, 1, 2, 1, 1, 1, 0, 0, 0, 0));
    cycle(nop());
    cycle(ins(7, 0, 2, 1, 1, 1, 0, 0, 0, 0));
    check("x0_fwdA", int'(fwdA), 0);

    // lw x5 ; add x6,x1,x5
    cycle(ins(5, 1, 0, 1, 0, 1, 1, 0, 1, 0));
    cycle(ins(6, 1, 5, 1, 1, 1, 0, 0, 0, 0));
    check("lu_stall", obs_stall, 1);
    check("lu_bubble", obs_bubble, 1);
    cycle(ins(6, 1, 5, 1, 1, 1, 0, 0, 0, 0));
    check("lu_release", obs_stall, 0);
    check("lu_fwdB", int'(fwdB), 2);
    check("lu_aluSrc2", int'(aluSrc2), 0);

    // jal, addi, double producer of x5
    cycle(ins(1, 0, 0, 0, 0, 1, 0, 0, 1, 1));
    check("jal_aluSrc2", int'(aluSrc2), 2);
    cycle(ins(8, 1, 0, 1, 0, 1, 0, 0, 1, 0));
    check("addi_aluSrc2", int'(aluSrc2), 1);
    cycle(ins(5, 1, 2, 1, 1, 1, 0, 0, 0, 0));
    cycle(ins(5, 3, 4, 1, 1, 1, 0, 0, 0, 0));
    cycle(ins(6, 5, 1, 1, 1, 1, 0, 0, 0, 0));
    check("dbl_fwdA", int'(fwdA), 1);

    // div x9 with done after 10 held cycles
    held = ins(10, 9, 1, 1, 1, 1, 0, 0, 0, 0);
    cycle(ins(9, 3, 4, 1, 1, 1, 0, 1, 0, 0));
    check("div_mcStart", int'(mcStart), 1);
    count_stalls(10, held);
    check("div_stall_cycles", stall_cnt, 10);
    done_s = held;
    done_s.done = 1'b1;
    cycle(done_s);
    check("div_done_stall", obs_stall, 0);
    check("div_next_fwdA", int'(fwdA), 1);

    // div with no done: timeout after MC_TIMEOUT busy cycles
    cycle(ins(11, 3, 4, 1, 1, 1, 0, 1, 0, 0));
    count_stalls(MC_TIMEOUT, held);
    check("to_stall_cycles", stall_cnt, MC_TIMEOUT);
    check("to_mcErr", int'(mcErr), 1);
    cycle(held);
    check("to_run", obs_stall, 0);

    // async reset in the middle of MC_BUSY
    cycle(ins(5, 3, 4, 1, 1, 1, 0, 1, 0, 0));
    count_stalls(3, held);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("midrst");
    drive(nop());
    model_reset();
    @(negedge clk);
    #1 rst_n = 1'b1;
    cycle(ins(6, 5, 1, 1, 1, 1, 0, 0, 0, 0));
    check("postrst_fwdA", int'(fwdA), 0);
    check("postrst_stall", obs_stall, 0);

    // randomized traffic over a small register window
    for (int i = 0; i < 800; i++) begin
      r.valid = ($urandom_range(0, 7) != 0);
      r.rs1 = $urandom_range(0, 7); r.rs2 = $urandom_range(0, 7);
      r.rd = $urandom_range(0, 7);
      r.u1 = $urandom_range(0, 1); r.u2 = $urandom_range(0, 1);
      r.wr = ($urandom_range(0, 3) != 0); r.ld = ($urandom_range(0, 3) == 0);
      r.mul = ($urandom_range(0, 15) == 0);
      r.imm = $urandom_range(0, 1); r.link = ($urandom_range(0, 7) == 0);
      r.done = ($urandom_range(0, 5) == 0);
      cycle(r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
